// File: rtl/if_prefetch_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// if_prefetch_pkg: shared defaults and redirect priority encoding
// rev 1.0
// ------------------------------------------------------------------
package if_prefetch_pkg;

  localparam int          c_ISA_WIDTH   = 32;
  localparam int          c_ROM_DEPTH   = 14;
  localparam int          c_QUEUE_DEPTH = 4;
  localparam logic [31:0] c_RESET_PC    = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_OFFSET = 2'd1,
    REDIR_JUMP   = 2'd2,
    REDIR_RESET  = 2'd3
  } redir_e;

  // pc_reset wins over an absolute jump, which wins over an offset branch
  function automatic redir_e redir_decode(input logic i_pc_reset,
                                          input logic i_jump,
                                          input logic i_offset);
    if (i_pc_reset) return REDIR_RESET;
    if (i_jump)     return REDIR_JUMP;
    if (i_offset)   return REDIR_OFFSET;
    return REDIR_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_prefetch_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// if_prefetch_fifo: prefetch queue of {instr, pc} with flush
// rev 1.0
// ------------------------------------------------------------------
module if_prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic                         o_valid,
  output logic [WIDTH-1:0]             o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_valid   = (r_count != '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && o_valid;
  // a pop frees the slot the simultaneous push lands in, even when full
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_head    = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// if_prefetch_unit: fetch PC, redirects, memory/UART mux, prefetch queue
// rev 1.0
// ------------------------------------------------------------------
module if_prefetch_unit
  import if_prefetch_pkg::*;
#(
  parameter int                   ISA_WIDTH   = c_ISA_WIDTH,
  parameter int                   ROM_DEPTH   = c_ROM_DEPTH,
  parameter int                   QUEUE_DEPTH = c_QUEUE_DEPTH,
  parameter logic [ISA_WIDTH-1:0] RESET_PC    = ISA_WIDTH'(c_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_uart_active,
  input  logic                 i_uart_we,
  input  logic [ROM_DEPTH:0]   i_uart_addr,
  input  logic [ISA_WIDTH-1:0] i_uart_data,
  input  logic                 i_redir_offset,
  input  logic                 i_redir_jump,
  input  logic                 i_pc_reset,
  input  logic [ISA_WIDTH-1:0] i_redir_base,
  input  logic [ISA_WIDTH-1:0] i_redir_value,
  input  logic                 i_out_ready,
  output logic                 o_out_valid,
  output logic [ISA_WIDTH-1:0] o_out_instr,
  output logic [ISA_WIDTH-1:0] o_out_pc,
  output logic                 o_mem_en,
  output logic                 o_mem_we,
  output logic [ROM_DEPTH-1:0] o_mem_addr,
  output logic [ISA_WIDTH-1:0] o_mem_wdata,
  input  logic [ISA_WIDTH-1:0] i_mem_rdata
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [ISA_WIDTH-1:0]   r_fetch_pc;
  logic [ISA_WIDTH-1:0]   r_req_pc;
  logic                   r_inflight;
  redir_e                 w_redir_sel;
  logic                   w_redir;
  logic [ISA_WIDTH-1:0]   w_target;
  logic                   w_issue;
  logic                   w_flush;
  logic                   w_pop;
  logic [CW-1:0]          w_count;
  logic [2*ISA_WIDTH-1:0] w_head;

  assign w_redir_sel = redir_decode(i_pc_reset, i_redir_jump, i_redir_offset);
  assign w_redir     = (w_redir_sel != REDIR_NONE);

  always_comb begin
    w_target = r_fetch_pc;
    case (w_redir_sel)
      REDIR_RESET:  w_target = RESET_PC;
      REDIR_JUMP:   w_target = i_redir_value;
      REDIR_OFFSET: w_target = i_redir_base + (i_redir_value << 2);
      default:      w_target = r_fetch_pc;
    endcase
  end

  // occupancy is taken before this cycle's pop, so a full queue stalls one cycle while draining
  assign w_issue = rst_n && !i_uart_active && !w_redir &&
                   (((CW+1)'(w_count) + (CW+1)'(r_inflight)) < (CW+1)'(QUEUE_DEPTH));
  assign w_flush = w_redir || i_uart_active;
  assign w_pop   = o_out_valid && i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_redir) begin
        r_fetch_pc <= w_target;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ISA_WIDTH'(4);
        r_req_pc   <= r_fetch_pc;
      end
    end
  end

  // a response landing in a flush cycle is dropped because flush dominates push
  if_prefetch_fifo #(
    .WIDTH (2*ISA_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({i_mem_rdata, r_req_pc}),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_valid (o_out_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign o_out_instr = w_head[2*ISA_WIDTH-1:ISA_WIDTH];
  assign o_out_pc    = w_head[ISA_WIDTH-1:0];

  always_comb begin
    o_mem_en    = w_issue;
    o_mem_we    = 1'b0;
    o_mem_addr  = r_fetch_pc[ROM_DEPTH+1:2];
    o_mem_wdata = '0;
    if (i_uart_active) begin
      o_mem_en    = i_uart_we;
      o_mem_we    = i_uart_we & ~i_uart_addr[ROM_DEPTH];
      o_mem_addr  = i_uart_addr[ROM_DEPTH-1:0];
      o_mem_wdata = i_uart_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_if_prefetch_unit: scoreboard bench for the instruction prefetch unit
// rev 1.0
// ------------------------------------------------------------------
module tb_if_prefetch_unit;

  localparam int          RD     = 14;
  localparam logic [31:0] RST_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          uart_active, uart_we;
  logic [RD:0]   uart_addr;
  logic [31:0]   uart_data;
  logic          redir_offset, redir_jump, pc_reset;
  logic [31:0]   redir_base, redir_value;
  logic          out_ready, out_valid;
  logic [31:0]   out_instr, out_pc;
  logic          mem_en, mem_we;
  logic [RD-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t exp_ent;
  int   total = 0;
  int   bad   = 0;

  if_prefetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_uart_active  (uart_active),
    .i_uart_we      (uart_we),
    .i_uart_addr    (uart_addr),
    .i_uart_data    (uart_data),
    .i_redir_offset (redir_offset),
    .i_redir_jump   (redir_jump),
    .i_pc_reset     (pc_reset),
    .i_redir_base   (redir_base),
    .i_redir_value  (redir_value),
    .i_out_ready    (out_ready),
    .o_out_valid    (out_valid),
    .o_out_instr    (out_instr),
    .o_out_pc       (out_pc),
    .o_mem_en       (mem_en),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // instruction memory: word at address a holds a*0x11, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= {18'd0, mem_addr} * 32'h11;
  end

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {18'd0, pc[15:2]} * 32'h11;
  endfunction

  task automatic push_exp(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = word_of(e.pc);
      sb.push_back(e);
    end
  endtask

  // every accepted head entry is popped from the scoreboard and compared
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got pc=%h instr=%h, want no output", out_pc, out_instr);
      end else begin
        exp_ent = sb.pop_front();
        if (out_pc !== exp_ent.pc || out_instr !== exp_ent.instr) begin
          bad++;
          $display("FAIL sb_data: got pc=%h instr=%h, want pc=%h instr=%h",
                   out_pc, out_instr, exp_ent.pc, exp_ent.instr);
        end
      end
    end
  end

  task automatic idle_inputs();
    uart_active = 0; uart_we = 0; uart_addr = '0; uart_data = '0;
    redir_offset = 0; redir_jump = 0; pc_reset = 0;
    redir_base = '0; redir_value = '0; out_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    sb.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", out_instr); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
  endtask

  task automatic test_streaming();
    int nvalid = 0;
    do_reset();
    out_ready = 1;
    push_exp(RST_PC, 10);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c == 0) begin
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL stream_issue: mem_en got %b want 1", mem_en); end
        total++; if (mem_addr !== 14'd0) begin bad++; $display("FAIL stream_addr: got %h want 0", mem_addr); end
      end
      if (c < 2) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_latency: cycle %0d valid got %b want 0", c, out_valid); end
      end else if (out_valid === 1'b1) begin
        nvalid++;
      end
      @(negedge clk);
    end
    out_ready = 0;
    total++; if (nvalid != 10) begin bad++; $display("FAIL stream_rate: valid cycles got %0d want 10", nvalid); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_left: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int n_en = 0;
    int nvalid = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mem_en === 1'b1) n_en++;
      if (c == 9) begin
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL bp_full_stall: mem_en got %b want 0", mem_en); end
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL bp_head: got valid=%b pc=%h want 1/0", out_valid, out_pc); end
      end
      @(negedge clk);
    end
    total++; if (n_en != 4) begin bad++; $display("FAIL bp_issues: got %0d want 4", n_en); end
    out_ready = 1;
    push_exp(RST_PC, 10);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid === 1'b1) nvalid++;
      @(negedge clk);
    end
    out_ready = 0;
    total++; if (nvalid != 10) begin bad++; $display("FAIL bp_gap: valid cycles got %0d want 10", nvalid); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_left: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_offset_branch();
    do_reset();
    out_ready = 1;
    push_exp(RST_PC, 4);
    for (int c = 0; c < 5; c++) begin
      #1;
      @(negedge clk);
    end
    redir_offset = 1; redir_base = 32'h20; redir_value = 32'hFFFF_FFFD;
    #1;
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL br_no_issue: mem_en got %b want 0", mem_en); end
    @(negedge clk);
    redir_offset = 0;
    push_exp(32'h14, 4);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c == 0) begin
        total++; if (mem_en !== 1'b1 || mem_addr !== 14'h5) begin bad++; $display("FAIL br_target: got en=%b addr=%h want 1/5", mem_en, mem_addr); end
      end
      if (c < 2) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL br_bubble: cycle %0d valid got %b want 0", c, out_valid); end
      end
      @(negedge clk);
    end
    out_ready = 0;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL br_left: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_priority();
    sb.delete();
    out_ready = 0;
    pc_reset = 1; redir_jump = 1; redir_offset = 1;
    redir_value = 32'h100; redir_base = 32'h20;
    #1;
    @(negedge clk);
    pc_reset = 0; redir_jump = 0; redir_offset = 0;
    out_ready = 1;
    push_exp(RST_PC, 4);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c == 0) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prio_flush: valid got %b want 0", out_valid); end
        total++; if (mem_addr !== RST_PC[15:2]) begin bad++; $display("FAIL prio_addr: got %h want %h", mem_addr, RST_PC[15:2]); end
      end
      @(negedge clk);
    end
    out_ready = 0;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL prio_left: got %0d pending want 0", sb.size()); end
    redir_jump = 1; redir_value = 32'h100;
    #1;
    @(negedge clk);
    redir_jump = 0;
    out_ready = 1;
    push_exp(32'h100, 4);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c == 0) begin
        total++; if (mem_addr !== 14'h40) begin bad++; $display("FAIL jump_addr: got %h want 40", mem_addr); end
      end
      @(negedge clk);
    end
    out_ready = 0;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL jump_left: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_uart();
    sb.delete();
    out_ready = 0;
    for (int c = 0; c < 4; c++) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL uart_pre: valid got %b want 1", out_valid); end
    @(negedge clk);
    uart_active = 1; uart_we = 1; uart_addr = 15'h0005; uart_data = 32'hDEAD_BEEF;
    #1;
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL uart_wr: got en=%b we=%b want 1/1", mem_en, mem_we); end
    total++; if (mem_addr !== 14'h5) begin bad++; $display("FAIL uart_addr: got %h want 5", mem_addr); end
    total++; if (mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL uart_data: got %h want deadbeef", mem_wdata); end
    @(negedge clk);
    uart_addr = 15'h4005;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL uart_flush: valid got %b want 0", out_valid); end
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL uart_dmem: got en=%b we=%b want 1/0", mem_en, mem_we); end
    @(negedge clk);
    uart_we = 0;
    #1;
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL uart_idle: mem_en got %b want 0", mem_en); end
    @(negedge clk);
    uart_active = 0; pc_reset = 1;
    #1;
    @(negedge clk);
    pc_reset = 0;
    out_ready = 1;
    push_exp(RST_PC, 3);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 0) begin
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RST_PC[15:2]) begin bad++; $display("FAIL uart_resume: got en=%b we=%b addr=%h want 1/0/%h", mem_en, mem_we, mem_addr, RST_PC[15:2]); end
      end
      @(negedge clk);
    end
    out_ready = 0;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL uart_left: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 4; c++) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b1 || out_pc !== RST_PC) begin bad++; $display("FAIL ar_pre: got valid=%b pc=%h want 1/%h", out_valid, out_pc, RST_PC); end
    #2;
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    total++; if (out_pc !== 32'h0 || mem_en !== 1'b0) begin bad++; $display("FAIL ar_state: got pc=%h en=%b want 0/0", out_pc, mem_en); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    sb.delete();
    out_ready = 1;
    push_exp(RST_PC, 3);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 2) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_latency: cycle %0d valid got %b want 0", c, out_valid); end
      end
      @(negedge clk);
    end
    out_ready = 0;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL ar_left: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_offset_branch();
    test_priority();
    test_uart();
    test_async_reset();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
